// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-count receiver: default sizes, FSM states and Gray/binary converters.
package gray_pkg;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int GRAY_MAX_W          = 64;

  typedef enum logic [1:0] {
    FILL,
    BASE,
    RUN
  } rxState_e;

  // Operates on a zero-extended word; callers truncate the result back to their own width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_rx_sync.sv
// Plain flop-chain synchronizer for a Gray word crossing into the CLK domain.
module gray_rx_sync
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/gray_count_receiver.sv
// Receives a foreign-domain Gray count and reports its binary value and per-cycle advance.
// Define GRAY_RX_ERRCHK_EN to flag illegal multi-bit Gray transitions on ERR.
module gray_count_receiver
  import gray_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] GRAY_I,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] BIN_Q,
  output logic [WIDTH-1:0] DELTA_Q,
  output logic             CHANGED,
  output logic             VALID,
  output logic             ERR
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0] syncGray;
  logic [WIDTH-1:0] decoded;
  rxState_e         state_q, state_d;
  logic [CNT_W-1:0] fillCnt_q, fillCnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             changed_q, changed_d;
  logic             valid_q, valid_d;

  gray_rx_sync #(
    .WIDTH(WIDTH),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d_i (GRAY_I),
    .q_o (syncGray)
  );

  assign decoded = WIDTH'(gray2bin(GRAY_MAX_W'(syncGray)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FILL;
      fillCnt_q <= '0;
      bin_q     <= '0;
      delta_q   <= '0;
      changed_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fillCnt_q <= fillCnt_d;
      bin_q     <= bin_d;
      delta_q   <= delta_d;
      changed_q <= changed_d;
      valid_q   <= valid_d;
    end
  end

  // FILL waits until the sync chain holds only post-reset samples; BASE takes a reference
  // so the first reported delta never spans a reset.
  always_comb begin
    state_d   = state_q;
    fillCnt_d = fillCnt_q;
    bin_d     = bin_q;
    delta_d   = delta_q;
    changed_d = changed_q;
    valid_d   = valid_q;
    case (state_q)
      FILL: begin
        if (fillCnt_q == CNT_W'(SYNC_STAGES - 1)) begin
          state_d = BASE;
        end else begin
          fillCnt_d = fillCnt_q + 1'b1;
        end
      end
      BASE: begin
        bin_d     = decoded;
        valid_d   = 1'b1;
        delta_d   = '0;
        changed_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        bin_d     = decoded;
        delta_d   = decoded - bin_q;
        changed_d = (decoded != bin_q);
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign BIN_Q   = bin_q;
  assign DELTA_Q = delta_q;
  assign CHANGED = changed_q;
  assign VALID   = valid_q;

`ifdef GRAY_RX_ERRCHK_EN
  logic [WIDTH-1:0] prevGray_q;
  logic             err_q, err_d;
  logic             illegalStep;

  // A legal Gray step flips at most one bit; a new error wins over a clear in the same cycle.
  assign illegalStep = (state_q == RUN) && ($countones(syncGray ^ prevGray_q) > 1);

  always_comb begin
    err_d = err_q;
    if (illegalStep) begin
      err_d = 1'b1;
    end else if (ERR_CLR) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prevGray_q <= '0;
      err_q      <= 1'b0;
    end else begin
      prevGray_q <= syncGray;
      err_q      <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unusedErrClr;
  assign unusedErrClr = ERR_CLR;
  assign ERR          = 1'b0;
`endif

endmodule
